// File: rtl/imem_window.sv
// imem_window: byte-wide instruction memory that serialises a 10-byte fetch window into a single word.
// Windows are loaded MSB-first, one byte per cycle. Out-of-range requests are answered with imem_error.
module imem_window #(
    parameter int MEM_DEPTH   = 256,
    parameter int INSTR_BYTES = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_en,
    input  logic [7:0]               load_addr,
    input  logic [7:0]               load_data,
    output logic                     load_ready,
    input  logic                     req_valid,
    input  logic [63:0]              req_pc,
    output logic                     req_ready,
    output logic                     win_valid,
    output logic [8*INSTR_BYTES-1:0] instr,
    output logic                     imem_error,
    input  logic                     win_ack
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(INSTR_BYTES);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pc;
    logic [CW-1:0] count;
    logic [7:0]    mem [MEM_DEPTH];
    logic          req_err;

    // Compare on the full 64 bits so that any nonzero high bits are flagged as out of range.
    assign req_err = req_pc > 64'(MEM_DEPTH - INSTR_BYTES);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // Error requests spend one READ cycle without touching memory, which gives them a latency of 1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = READ;
            READ:    if (imem_error || count == CW'(INSTR_BYTES - 1)) state_nxt = RESP;
            RESP:    if (win_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = state == IDLE;
        load_ready = state == IDLE;
        win_valid  = state == RESP;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc         <= '0;
            count      <= '0;
            instr      <= '0;
            imem_error <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            pc         <= req_pc[AW-1:0];
            count      <= '0;
            instr      <= '0;
            imem_error <= req_err;
        end else if (state == READ && !imem_error) begin
            instr <= {instr[8*INSTR_BYTES-9:0], mem[pc + AW'(count)]};
            count <= count + 1'b1;
        end

    // Memory contents survive reset on purpose.
    always_ff @(posedge clk)
        if (load_en && load_ready) mem[AW'(load_addr)] <= load_data;
endmodule

// File: tb/tb_imem_window.sv
// tb_imem_window: directed scoreboard bench for imem_window.
module tb_imem_window;
    logic        clk = 0, rst_n = 0, load_en = 0, req_valid = 0, win_ack = 0;
    logic [7:0]  load_addr = 0, load_data = 0;
    logic [63:0] req_pc = 0;
    logic        load_ready, req_ready, win_valid, imem_error;
    logic [79:0] instr, got;
    logic [7:0]  model [256];
    logic [7:0]  spec_b [10] = '{8'h30, 8'hF2, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [80:0] sb [$];
    int          tests = 0, failed = 0;

    always #5 clk = ~clk;

    imem_window dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .win_valid(win_valid), .instr(instr), .imem_error(imem_error), .win_ack(win_ack)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [80:0] model_win(input logic [63:0] pc);
        logic [79:0] w;
        w = '0;
        if (pc > 64'd246) return {1'b1, 80'h0};
        for (int i = 0; i < 10; i++) w = {w[71:0], model[pc[7:0] + 8'(i)]};
        return {1'b0, w};
    endfunction

    task automatic window(input logic [63:0] pc, input int hold, input bit poke, input bit do_load,
                          input logic [7:0] la, input logic [7:0] ld, output logic [79:0] seen);
        logic [80:0] e;
        int lat, exp_lat;
        @(negedge clk);
        if (do_load) begin
            load_en = 1; load_addr = la; load_data = ld; model[la] = ld;
        end
        req_valid = 1; req_pc = pc;
        sb.push_back(model_win(pc));
        exp_lat = model_win(pc)[80] ? 1 : 10;
        chk("req_ready_idle", 80'(req_ready), 80'(1));
        @(posedge clk); #1 req_valid = 0; load_en = 0;
        lat = 0;
        while (!win_valid && lat < 20) begin
            @(posedge clk); #1 lat++;
            if (poke && lat == 3) begin
                chk("load_ready_read", 80'(load_ready), 80'(0));
                load_en = 1; load_addr = 8'd8; load_data = 8'hAA;
            end else load_en = 0;
        end
        load_en = 0;
        chk("latency", 80'(lat), 80'(exp_lat));
        e = sb.pop_front();
        seen = instr;
        chk("instr", instr, e[79:0]);
        chk("imem_error", 80'(imem_error), 80'(e[80]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); req_valid = 1; req_pc = 64'd20;
            @(posedge clk); #1;
            chk("hold_valid", 80'(win_valid), 80'(1));
            chk("hold_instr", instr, e[79:0]);
            chk("hold_err", 80'(imem_error), 80'(e[80]));
            chk("hold_req_ready", 80'(req_ready), 80'(0));
        end
        @(negedge clk); req_valid = 0; win_ack = 1;
        @(posedge clk); #1 win_ack = 0;
        chk("ack_valid_low", 80'(win_valid), 80'(0));
        chk("ack_req_ready", 80'(req_ready), 80'(1));
    endtask

    initial begin
        #2;
        chk("rst_win_valid", 80'(win_valid), 80'(0));
        chk("rst_req_ready", 80'(req_ready), 80'(1));
        chk("rst_load_ready", 80'(load_ready), 80'(1));
        chk("rst_instr", instr, 80'h0);
        chk("rst_err", 80'(imem_error), 80'(0));
        @(negedge clk); rst_n = 1;
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            load_en = 1; load_addr = 8'(a);
            load_data = (a >= 6 && a <= 15) ? spec_b[a-6] : 8'(a * 37 + 11);
            model[a] = load_data;
        end
        @(negedge clk); load_en = 0;
        window(64'd6, 0, 0, 0, 0, 0, got);
        chk("req039_literal", got, 80'h30F2_7800_0000_0000_0000);
        window(64'd247, 0, 0, 0, 0, 0, got);
        window(64'd246, 0, 0, 0, 0, 0, got);
        chk("last_byte_255", 80'(got[7:0]), 80'(model[255]));
        window(64'h1_0000_0006, 0, 0, 0, 0, 0, got);
        window(64'd6, 5, 0, 0, 0, 0, got);
        window(64'd6, 0, 1, 0, 0, 0, got);
        window(64'd6, 0, 0, 0, 0, 0, got);
        window(64'd100, 0, 0, 1, 8'd104, 8'hC3, got);
        @(negedge clk); req_valid = 1; req_pc = 64'd6;
        @(posedge clk); #1 req_valid = 0;
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_win_valid", 80'(win_valid), 80'(0));
        chk("abort_instr", instr, 80'h0);
        chk("abort_req_ready", 80'(req_ready), 80'(1));
        chk("abort_load_ready", 80'(load_ready), 80'(1));
        @(negedge clk); rst_n = 1;
        repeat (12) @(posedge clk);
        #1 chk("abort_no_resp", 80'(win_valid), 80'(0));
        window(64'd6, 0, 0, 0, 0, 0, got);
        chk("req039_after_rst", got, 80'h30F2_7800_0000_0000_0000);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
